// File: rtl/pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// pipe_stage_reg
//   Parametrised, handshaked pipeline-stage register for the SQED RISC-V core.
//   Carries an opaque data bus, a control bus and the QED valid tag between
//   two pipeline stages. The stage holds a main entry, which drives the
//   outputs, and a skid entry. The skid entry absorbs one instruction while
//   downstream stalls, so in_ready can be a plain register.
//
// Parameters
//   DATA_W      width of the data payload
//   CTRL_W      width of the control payload
//   CTRL_BUBBLE control value presented whenever out_valid=0
//   CNT_W       width of the saturating stall-cycle counter
//
// Ports
//   clk         clock, rising-edge active
//   reset       synchronous, active-high reset (overrides flush and traffic)
//   in_valid    upstream holds a valid instruction
//   in_ready    stage can accept; registered (equals !skid valid)
//   in_data     data payload
//   in_ctrl     control payload
//   in_qed_vld  QED valid tag of the incoming instruction
//   flush       squash both held entries; the next cycle shows a bubble
//   out_valid   main entry holds a valid instruction
//   out_ready   downstream accepts this cycle
//   out_data    data of the main entry (holds last value when empty)
//   out_ctrl    control of the main entry, CTRL_BUBBLE when empty
//   out_qed_vld QED tag of the main entry, 0 when empty
//   stall_cnt   cycles with out_valid=1 and out_ready=0, saturating
// ---------------------------------------------------------------------------
module pipe_stage_reg #(
  parameter int unsigned        DATA_W      = 96,
  parameter int unsigned        CTRL_W      = 11,
  parameter logic [CTRL_W-1:0]  CTRL_BUBBLE = {CTRL_W{1'b0}},
  parameter int unsigned        CNT_W       = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              in_qed_vld,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic              out_qed_vld,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  // Saturating increment: sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
    logic [CNT_W-1:0] result;
    if (value == CNT_MAX) begin
      result = value;
    end else begin
      result = value + CNT_ONE;
    end
    return result;
  endfunction

  // Main entry state. The ctrl and qed registers are kept at their bubble
  // values whenever the valid bit is clear, so the outputs can be driven
  // straight from flops.
  logic              main_valid_r;
  logic [DATA_W-1:0] main_data_r;
  logic [CTRL_W-1:0] main_ctrl_r;
  logic              main_qed_r;

  // Skid entry state.
  logic              skid_valid_r;
  logic [DATA_W-1:0] skid_data_r;
  logic [CTRL_W-1:0] skid_ctrl_r;
  logic              skid_qed_r;

  logic              in_ready_r;
  logic [CNT_W-1:0]  stall_cnt_r;

  // Next-state values.
  logic              main_valid_s;
  logic [DATA_W-1:0] main_data_s;
  logic [CTRL_W-1:0] main_ctrl_s;
  logic              main_qed_s;
  logic              skid_valid_s;
  logic [DATA_W-1:0] skid_data_s;
  logic [CTRL_W-1:0] skid_ctrl_s;
  logic              skid_qed_s;
  logic              in_ready_s;
  logic [CNT_W-1:0]  stall_cnt_s;

  logic              in_fire_s;
  logic              out_fire_s;
  logic              main_free_s;

  // Handshake decode.
  always_comb begin
    in_fire_s   = in_valid & in_ready_r;
    out_fire_s  = main_valid_r & out_ready;
    // Main can take a new entry when empty or when its content leaves now.
    main_free_s = ~main_valid_r | out_fire_s;
  end

  // Entry movement between input, skid and main, including flush squash.
  always_comb begin
    main_valid_s = main_valid_r;
    main_data_s  = main_data_r;
    main_ctrl_s  = main_ctrl_r;
    main_qed_s   = main_qed_r;
    skid_valid_s = skid_valid_r;
    skid_data_s  = skid_data_r;
    skid_ctrl_s  = skid_ctrl_r;
    skid_qed_s   = skid_qed_r;

    if (flush) begin
      // Squash both entries; any in_fire this cycle is dropped. Data keeps
      // its stale value since it is don't-care while out_valid=0.
      main_valid_s = 1'b0;
      main_ctrl_s  = CTRL_BUBBLE;
      main_qed_s   = 1'b0;
      skid_valid_s = 1'b0;
      skid_ctrl_s  = CTRL_BUBBLE;
      skid_qed_s   = 1'b0;
    end else if (main_free_s) begin
      if (skid_valid_r) begin
        // Skid is older than anything upstream; it moves first to keep
        // FIFO order. in_ready is 0 here, so no in_fire can collide.
        main_valid_s = 1'b1;
        main_data_s  = skid_data_r;
        main_ctrl_s  = skid_ctrl_r;
        main_qed_s   = skid_qed_r;
        skid_valid_s = 1'b0;
        skid_ctrl_s  = CTRL_BUBBLE;
        skid_qed_s   = 1'b0;
      end else if (in_fire_s) begin
        main_valid_s = 1'b1;
        main_data_s  = in_data;
        main_ctrl_s  = in_ctrl;
        main_qed_s   = in_qed_vld;
      end else begin
        main_valid_s = 1'b0;
        main_ctrl_s  = CTRL_BUBBLE;
        main_qed_s   = 1'b0;
      end
    end else begin
      // Main is holding against backpressure; an accepted input parks in
      // skid. in_ready=0 whenever skid is full, so skid is empty here.
      if (in_fire_s) begin
        skid_valid_s = 1'b1;
        skid_data_s  = in_data;
        skid_ctrl_s  = in_ctrl;
        skid_qed_s   = in_qed_vld;
      end else begin
        skid_valid_s = skid_valid_r;
      end
    end

    // Upstream ready only ever looks at our own next skid state.
    in_ready_s = ~skid_valid_s;
  end

  // Stall counter: counts visible backpressure cycles; flush does not clear.
  always_comb begin
    if (main_valid_r && !out_ready) begin
      stall_cnt_s = sat_inc(stall_cnt_r);
    end else begin
      stall_cnt_s = stall_cnt_r;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      main_valid_r <= 1'b0;
      main_data_r  <= {DATA_W{1'b0}};
      main_ctrl_r  <= CTRL_BUBBLE;
      main_qed_r   <= 1'b0;
      skid_valid_r <= 1'b0;
      skid_data_r  <= {DATA_W{1'b0}};
      skid_ctrl_r  <= CTRL_BUBBLE;
      skid_qed_r   <= 1'b0;
      in_ready_r   <= 1'b1;
      stall_cnt_r  <= {CNT_W{1'b0}};
    end else begin
      main_valid_r <= main_valid_s;
      main_data_r  <= main_data_s;
      main_ctrl_r  <= main_ctrl_s;
      main_qed_r   <= main_qed_s;
      skid_valid_r <= skid_valid_s;
      skid_data_r  <= skid_data_s;
      skid_ctrl_r  <= skid_ctrl_s;
      skid_qed_r   <= skid_qed_s;
      in_ready_r   <= in_ready_s;
      stall_cnt_r  <= stall_cnt_s;
    end
  end

  // Outputs come straight from flops.
  always_comb begin
    in_ready    = in_ready_r;
    out_valid   = main_valid_r;
    out_data    = main_data_r;
    out_ctrl    = main_ctrl_r;
    out_qed_vld = main_qed_r;
    stall_cnt   = stall_cnt_r;
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// ---------------------------------------------------------------------------
// tb_pipe_stage_reg
//   Directed bench for pipe_stage_reg (DATA_W=96, CTRL_W=11, CTRL_BUBBLE=0,
//   CNT_W=2). Inputs change 1 time unit after the rising edge and outputs
//   are checked at that same point, i.e. well away from the next edge.
// ---------------------------------------------------------------------------
module tb_pipe_stage_reg;

  localparam int unsigned DATA_W = 96;
  localparam int unsigned CTRL_W = 11;
  localparam int unsigned CNT_W  = 2;

  logic              clk;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic [CTRL_W-1:0] in_ctrl;
  logic              in_qed_vld;
  logic              flush;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CTRL_W-1:0] out_ctrl;
  logic              out_qed_vld;
  logic [CNT_W-1:0]  stall_cnt;

  int checks;
  int errors;

  pipe_stage_reg #(
    .DATA_W      (DATA_W),
    .CTRL_W      (CTRL_W),
    .CTRL_BUBBLE (11'h000),
    .CNT_W       (CNT_W)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .in_ctrl     (in_ctrl),
    .in_qed_vld  (in_qed_vld),
    .flush       (flush),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_ctrl    (out_ctrl),
    .out_qed_vld (out_qed_vld),
    .stall_cnt   (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs,
                     input logic [DATA_W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [DATA_W-1:0] d,
                       input logic [CTRL_W-1:0] c, input logic q);
    in_valid   = v;
    in_data    = d;
    in_ctrl    = c;
    in_qed_vld = q;
  endtask

  logic [CNT_W-1:0] stall_exp [6];

  initial begin
    checks = 0;
    errors = 0;
    stall_exp[0] = 2'd1; stall_exp[1] = 2'd2; stall_exp[2] = 2'd3;
    stall_exp[3] = 2'd3; stall_exp[4] = 2'd3; stall_exp[5] = 2'd3;

    // Reset for two cycles.
    reset = 1'b1; flush = 1'b0; out_ready = 1'b0;
    drive(1'b0, 96'h0, 11'h0, 1'b0);
    tick(); tick();
    chk("rst_out_valid", out_valid, 96'd0);
    chk("rst_out_ctrl",  out_ctrl,  96'd0);
    chk("rst_out_qed",   out_qed_vld, 96'd0);
    chk("rst_out_data",  out_data,  96'd0);
    chk("rst_in_ready",  in_ready,  96'd1);
    chk("rst_stall",     stall_cnt, 96'd0);

    // Pass-through with one-cycle latency.
    reset = 1'b0; out_ready = 1'b1;
    drive(1'b1, 96'hABC, 11'h7FF, 1'b1);
    tick();
    chk("pt_out_valid", out_valid, 96'd1);
    chk("pt_out_data",  out_data,  96'hABC);
    chk("pt_out_ctrl",  out_ctrl,  96'h7FF);
    chk("pt_out_qed",   out_qed_vld, 96'd1);

    // Four back-to-back entries, one per cycle, in order.
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 96'h100 + 96'(i), 11'(i + 1), 1'(i));
      tick();
      chk("b2b_valid", out_valid, 96'd1);
      chk("b2b_data",  out_data,  96'h100 + 96'(i));
      chk("b2b_ctrl",  out_ctrl,  96'(i + 1));
      chk("b2b_qed",   out_qed_vld, 96'(i % 2));
    end

    // Idle: bubble control even though data is stale.
    drive(1'b0, 96'hFFFF, 11'h7FF, 1'b1);
    tick();
    chk("idle_valid", out_valid, 96'd0);
    chk("idle_ctrl",  out_ctrl,  96'd0);
    chk("idle_qed",   out_qed_vld, 96'd0);
    tick();
    chk("idle2_ctrl", out_ctrl,  96'd0);
    chk("idle_stall", stall_cnt, 96'd0);

    // Backpressure: A into main, B into skid.
    out_ready = 1'b0;
    drive(1'b1, 96'hAAAA, 11'h155, 1'b1);
    tick();
    chk("bp_a_data",  out_data, 96'hAAAA);
    chk("bp_a_ready", in_ready, 96'd1);
    drive(1'b1, 96'hBBBB, 11'h2AA, 1'b0);
    tick();
    chk("bp_b_ready", in_ready, 96'd0);
    chk("bp_hold_a",  out_data, 96'hAAAA);
    chk("bp_stall",   stall_cnt, 96'd1);
    // Offer D while in_ready=0: must not be taken.
    drive(1'b1, 96'hDDDD, 11'h0DD, 1'b1);
    tick();
    chk("bp_hold_a2", out_data, 96'hAAAA);
    chk("bp_stall2",  stall_cnt, 96'd2);
    drive(1'b0, 96'h0, 11'h0, 1'b0);
    out_ready = 1'b1;
    tick();
    chk("bp_b_data",  out_data, 96'hBBBB);
    chk("bp_b_ctrl",  out_ctrl, 96'h2AA);
    chk("bp_b_qed",   out_qed_vld, 96'd0);
    chk("bp_ready_back", in_ready, 96'd1);
    tick();
    chk("bp_drained", out_valid, 96'd0);

    // Flush with both entries full and an input offered.
    out_ready = 1'b0;
    drive(1'b1, 96'hEEEE, 11'h0EE, 1'b1);
    tick();
    drive(1'b1, 96'hF0F0, 11'h0F0, 1'b1);
    tick();
    chk("fl_full_ready", in_ready, 96'd0);
    flush = 1'b1;
    drive(1'b1, 96'hCCCC, 11'h0CC, 1'b1);
    tick();
    chk("fl_valid", out_valid, 96'd0);
    chk("fl_ctrl",  out_ctrl,  96'd0);
    chk("fl_qed",   out_qed_vld, 96'd0);
    chk("fl_ready", in_ready,  96'd1);
    chk("fl_stall_kept", stall_cnt, 96'd3);
    // Flush with in_ready=1: the accepted C is discarded.
    tick();
    chk("fl2_valid", out_valid, 96'd0);
    flush = 1'b0;
    drive(1'b0, 96'h0, 11'h0, 1'b0);
    out_ready = 1'b1;
    tick();
    chk("fl_no_c", out_valid, 96'd0);
    chk("fl_stall_kept2", stall_cnt, 96'd3);

    // Stall counter saturation from a clean reset.
    reset = 1'b1;
    tick();
    chk("sc_rst", stall_cnt, 96'd0);
    reset = 1'b0; out_ready = 1'b0;
    drive(1'b1, 96'h5, 11'h001, 1'b1);
    tick();
    drive(1'b0, 96'h0, 11'h0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("sc_seq", stall_cnt, 96'(stall_exp[i]));
    end

    // Reset mid-operation with both entries valid and flush asserted.
    drive(1'b1, 96'h6666, 11'h066, 1'b1);
    tick();
    chk("rm_full", in_ready, 96'd0);
    reset = 1'b1; flush = 1'b1;
    drive(1'b1, 96'h7777, 11'h077, 1'b1);
    tick();
    chk("rm_valid", out_valid, 96'd0);
    chk("rm_ctrl",  out_ctrl,  96'd0);
    chk("rm_qed",   out_qed_vld, 96'd0);
    chk("rm_data",  out_data,  96'd0);
    chk("rm_ready", in_ready,  96'd1);
    chk("rm_stall", stall_cnt, 96'd0);
    reset = 1'b0; flush = 1'b0; out_ready = 1'b1;
    drive(1'b0, 96'h0, 11'h0, 1'b0);
    tick();
    chk("rm_empty", out_valid, 96'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised, handshaked pipeline-stage register for the SQED RISC-V core; the successor to the fixed-field EX/MEM latch.
- Carries an opaque data bus, a control-signal bus and the QED valid bit between any two stages (ID/EX, EX/MEM, MEM/WB).
- Adds a valid/ready handshake with a 2-entry skid buffer, so upstream ready is fully registered.
- Adds flush with bubble insertion (control forced to a safe value) and a saturating stall-cycle counter for verification.

Parameters:
DATA_W, 96, width of data payload (e.g. pc_branch, alu_res, reg_data2 concatenated)
CTRL_W, 11, width of control payload (rd, memRead, memWrite, branch, memtoReg, regWrite, alu_zero)
CTRL_BUBBLE, 0, control value presented whenever out_valid=0 (must deassert all write enables)
CNT_W, 16, width of stall-cycle counter

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
in_valid  input  1  upstream holds a valid instruction
in_ready  output  1  stage can accept; registered, never depends combinationally on out_ready
in_data  input  DATA_W  data payload
in_ctrl  input  CTRL_W  control payload
in_qed_vld  input  1  QED valid tag of incoming instruction
flush  input  1  squash all held entries (branch taken / mispredict)
out_valid  output  1  main entry holds a valid instruction
out_ready  input  1  downstream accepts this cycle
out_data  output  DATA_W  data of main entry
out_ctrl  output  CTRL_W  control of main entry, or CTRL_BUBBLE when out_valid=0
out_qed_vld  output  1  QED tag of main entry; 0 when out_valid=0
stall_cnt  output  CNT_W  cycles with out_valid=1 and out_ready=0, saturating

Behaviour:
- Storage: main entry (drives outputs) and skid entry; each has a valid bit, data, ctrl and qed field.
- Transfer rules: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- Reset: both valid bits=0; out_valid=0; out_ctrl=CTRL_BUBBLE; out_qed_vld=0; out_data=0; in_ready=1; stall_cnt=0. Reset overrides flush and all traffic.
- in_ready is a register equal to !skid_valid after each update. It must never be 0 while skid is empty.
- Update rules, evaluated when not in reset or flush:
  - Main empty, or main firing: main loads skid if skid is valid, else in_* if in_fire, else main becomes empty. Skid empties whenever its content moves to main.
  - Main holding (valid, !out_ready) and in_fire: the incoming entry goes to skid. in_fire with skid already full cannot occur, since in_ready=0.
  - Simultaneous out_fire and in_fire with skid full: not possible (in_ready=0). With skid empty, the incoming entry goes directly into main.
- Latency: 1 cycle from in_fire to out_valid when the stage is empty. Order is strictly FIFO; back-to-back throughput is 1 per cycle while out_ready=1.
- Flush, synchronous, 1 cycle:
  - Next cycle both valid bits=0, out_ctrl=CTRL_BUBBLE, out_qed_vld=0, in_ready=1.
  - An in_fire in the flush cycle is discarded; in_ready stays at its registered value during that cycle.
  - stall_cnt is not cleared by flush.
- Bubble rule: whenever out_valid=0, out_ctrl=CTRL_BUBBLE and out_qed_vld=0. out_data holds its last value (don't-care).
- stall_cnt increments in any cycle where out_valid & !out_ready. It saturates at 2^CNT_W-1 and clears only on reset.
- Data and ctrl are captured bit-exact; no width conversion.

Test Plan:
- Reset then pass-through:
  - Stimulus: reset 2 cycles, then in_valid=1, in_data=0x...0ABC, in_ctrl=0x7FF, in_qed_vld=1, out_ready=1.
  - Required: next cycle out_valid=1, out_data=0x...0ABC, out_ctrl=0x7FF, out_qed_vld=1; 4 back-to-back inputs emerge in order at 1 per cycle.
- Backpressure / skid:
  - Stimulus: out_ready=0, send A then B.
  - Required: A in main, B in skid, in_ready=0 on the cycle after B; out_ready=1 for 2 cycles yields A then B; in_ready returns to 1 one cycle after A leaves.
- Flush with full stage:
  - Stimulus: main and skid valid, assert flush with in_valid=1 carrying C.
  - Required: next cycle out_valid=0, out_ctrl=CTRL_BUBBLE, out_qed_vld=0, in_ready=1; C never appears.
- Bubble control:
  - Stimulus: CTRL_BUBBLE=0, idle input.
  - Required: out_ctrl=0 and out_qed_vld=0 on every idle cycle, regardless of stale data.
- Stall counter:
  - Stimulus: CNT_W=2, hold a valid entry with out_ready=0 for 6 cycles.
  - Required: stall_cnt sequence 1,2,3,3,3,3; value retained through flush; reset returns it to 0.
- Reset mid-operation:
  - Stimulus: reset asserted with both entries valid and flush=1.
  - Required: all outputs at their reset values next cycle, in_ready=1.
